// File: rtl/mmio_hub.sv
// mmio_hub: peripheral hub between the core data port and data memory.
// Decodes a 256-byte MMIO window, keeps core writes to that window away from
// data memory, and serves a UART TX FIFO, a cycle counter and a drop counter.
// Everything outside the window passes through to data memory unchanged.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   dmemAddr/Wdata/Size   core data-port address, write data and access size
//   dmemWen               core write enable
//   dmemRdata             read data returned to the core (combinational mux)
//   memWen                data-memory write enable (dmemWen outside the window)
//   memRdata              read data from data memory
//   uartData/uartValid    FIFO head byte and non-empty flag
//   uartReady             sink accepts the head byte
module mmio_hub #(
  parameter logic [31:0]  MMIO_BASE  = 32'hFFFF_FF00,
  parameter int unsigned  FIFO_DEPTH = 8,
  parameter int unsigned  CNT_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmemAddr,
  input  logic [31:0] dmemWdata,
  input  logic [2:0]  dmemSize,
  input  logic        dmemWen,
  output logic [31:0] dmemRdata,
  output logic        memWen,
  input  logic [31:0] memRdata,
  output logic [7:0]  uartData,
  output logic        uartValid,
  input  logic        uartReady
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = PTR_W + 1;

  // Word offsets (dmemAddr[7:2]) of the registers inside the window
  localparam logic [5:0] OFF_UART_TX   = 6'h3F;
  localparam logic [5:0] OFF_UART_STAT = 6'h3E;
  localparam logic [5:0] OFF_CNT_CTRL  = 6'h3D;
  localparam logic [5:0] OFF_CNT_LO    = 6'h3C;
  localparam logic [5:0] OFF_CNT_HI    = 6'h3B;
  localparam logic [5:0] OFF_DROPS     = 6'h3A;

  logic             mmio_sel;
  logic [5:0]       word;
  logic             reg_wr;
  logic [31:0]      reg_rdata;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             empty;
  logic             push_req;
  logic             push_ok;
  logic             pop;
  logic             drop;

  logic [15:0]      drops;
  logic             drops_clr;

  logic                 run;
  logic [CNT_WIDTH-1:0] cnt;
  logic [63:0]          cnt_ext;
  logic                 ctrl_wr;

  // dmemSize only matters to data memory; the hub ignores it
  logic unused_size;
  assign unused_size = ^dmemSize;

  // Address decode and memory write gating
  assign mmio_sel = (dmemAddr[31:8] == MMIO_BASE[31:8]);
  assign word     = dmemAddr[7:2];
  assign reg_wr   = dmemWen && mmio_sel;
  assign memWen   = dmemWen && !mmio_sel;

  // FIFO status and handshake
  assign full      = (level == LVL_W'(FIFO_DEPTH));
  assign empty     = (level == '0);
  assign uartValid = !empty;
  assign uartData  = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign pop       = uartValid && uartReady;
  assign push_req  = reg_wr && (word == OFF_UART_TX);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;

  assign drops_clr = reg_wr && (word == OFF_DROPS);
  assign ctrl_wr   = reg_wr && (word == OFF_CNT_CTRL);

  assign cnt_ext   = 64'(cnt);

  // Register read mux; unmapped offsets read zero
  always_comb begin
    reg_rdata = 32'h0;
    case (word)
      OFF_UART_STAT: reg_rdata = {16'h0, 8'(level), 6'h0, full, empty};
      OFF_CNT_CTRL:  reg_rdata = {31'h0, run};
      OFF_CNT_LO:    reg_rdata = cnt_ext[31:0];
      OFF_CNT_HI:    reg_rdata = cnt_ext[63:32];
      OFF_DROPS:     reg_rdata = {16'h0, drops};
      default:       reg_rdata = 32'h0;
    endcase
  end

  assign dmemRdata = mmio_sel ? reg_rdata : memRdata;

  // FIFO storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= dmemWdata[7:0];
    end
  end

  // FIFO pointers and level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating drop counter; a clear beats a simultaneous drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drops <= 16'h0;
    end else if (drops_clr) begin
      drops <= 16'h0;
    end else if (drop && (drops != 16'hFFFF)) begin
      drops <= drops + 16'd1;
    end
  end

  // Cycle counter: increments on the old run value, clear overrides
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0;
      cnt <= '0;
    end else begin
      if (ctrl_wr) run <= dmemWdata[0];
      if (ctrl_wr && dmemWdata[1]) begin
        cnt <= '0;
      end else if (run) begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_mmio_hub.sv
// tb_mmio_hub: directed self-checking bench for mmio_hub. A second instance
// with a 40-bit counter covers the wide-counter wrap.
module tb_mmio_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dmemAddr;
  logic [31:0] dmemWdata;
  logic [2:0]  dmemSize;
  logic        dmemWen;
  logic [31:0] dmemRdata;
  logic        memWen;
  logic [31:0] memRdata;
  logic [7:0]  uartData;
  logic        uartValid;
  logic        uartReady;

  logic [31:0] a40;
  logic [31:0] wd40;
  logic        wen40;
  logic [31:0] rd40;
  logic        mwen40;
  logic [7:0]  ud40;
  logic        uv40;

  logic [31:0] mem [64];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  mmio_hub #(.MMIO_BASE(32'hFFFF_FF00), .FIFO_DEPTH(8), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemSize(dmemSize),
    .dmemWen(dmemWen), .dmemRdata(dmemRdata), .memWen(memWen),
    .memRdata(memRdata), .uartData(uartData), .uartValid(uartValid),
    .uartReady(uartReady)
  );

  mmio_hub #(.MMIO_BASE(32'hFFFF_FF00), .FIFO_DEPTH(8), .CNT_WIDTH(40)) dut40 (
    .clk(clk), .rst(rst),
    .dmemAddr(a40), .dmemWdata(wd40), .dmemSize(3'd2),
    .dmemWen(wen40), .dmemRdata(rd40), .memWen(mwen40),
    .memRdata(32'h0), .uartData(ud40), .uartValid(uv40),
    .uartReady(1'b0)
  );

  // Small data-memory model behind the hub
  assign memRdata = mem[dmemAddr[7:2]];
  always @(posedge clk) begin
    if (memWen) mem[dmemAddr[7:2]] <= dmemWdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dmemAddr  = a;
    dmemWdata = d;
    dmemWen   = 1'b1;
    @(posedge clk);
    #1;
    dmemWen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmemAddr = a;
    dmemWen  = 1'b0;
    #1;
    d = dmemRdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst = 1'b1; dmemAddr = 32'h0; dmemWdata = 32'h0; dmemSize = 3'd2;
    dmemWen = 1'b0; uartReady = 1'b0;
    a40 = 32'h0; wd40 = 32'h0; wen40 = 1'b0;
    #1;
    check("rst_valid", 32'(uartValid), 32'h0);
    check("rst_data", 32'(uartData), 32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Reset register state
    rd(32'hFFFF_FFF8, rv); check("rst_stat", rv, 32'h0000_0001);
    rd(32'hFFFF_FFF0, rv); check("rst_cnt_lo", rv, 32'h0);
    rd(32'hFFFF_FFE8, rv); check("rst_drops", rv, 32'h0);
    idle(1);

    // Pass-through write and readback
    dmemAddr = 32'h0000_0100; dmemWdata = 32'h1234_5678; dmemWen = 1'b1;
    #1; check("pt_memwen", 32'(memWen), 32'h1);
    @(posedge clk); #1; dmemWen = 1'b0;
    rd(32'h0000_0100, rv); check("pt_readback", rv, 32'h1234_5678);
    dmemAddr = 32'hFFFF_FFFC; dmemWdata = 32'h0000_0000; dmemWen = 1'b1;
    #1; check("mmio_memwen", 32'(memWen), 32'h0);
    dmemWen = 1'b0;
    idle(1);
    rd(32'hFFFF_FFFC, rv); check("tx_reads_zero", rv, 32'h0);
    rd(32'hFFFF_FF00, rv); check("unmapped_zero", rv, 32'h0);
    idle(1);

    // Fill past depth: 8 accepted, 2 dropped
    for (int i = 0; i < 10; i++) begin
      wr(32'hFFFF_FFFC, 32'(8'h41 + i));
      if (i == 0) check("push_latency", 32'(uartData), 32'h41);
    end
    rd(32'hFFFF_FFF8, rv); check("fill_stat", rv, 32'h0000_0802);
    rd(32'hFFFF_FFE8, rv); check("fill_drops", rv, 32'h2);
    idle(1);
    uartReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid%0d", i), 32'(uartValid), 32'h1);
      check($sformatf("drain_data%0d", i), 32'(uartData), 32'(8'h41 + i));
      @(posedge clk); #1;
    end
    check("drained_valid", 32'(uartValid), 32'h0);
    check("drained_data", 32'(uartData), 32'h0);
    uartReady = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) wr(32'hFFFF_FFFC, 32'(8'h61 + i));
    uartReady = 1'b1;
    dmemAddr = 32'hFFFF_FFFC; dmemWdata = 32'h5A; dmemWen = 1'b1;
    @(posedge clk); #1;
    dmemWen = 1'b0; uartReady = 1'b0;
    rd(32'hFFFF_FFF8, rv); check("pp_stat", rv, 32'h0000_0802);
    rd(32'hFFFF_FFE8, rv); check("pp_drops", rv, 32'h2);
    idle(1);
    uartReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("pp_data%0d", i), 32'(uartData), (i == 7) ? 32'h5A : 32'(8'h62 + i));
      @(posedge clk); #1;
    end
    check("pp_empty", 32'(uartValid), 32'h0);
    uartReady = 1'b0;

    // Drops clear
    wr(32'hFFFF_FFE8, 32'h0);
    rd(32'hFFFF_FFE8, rv); check("drops_clr", rv, 32'h0);
    idle(1);

    // Counter: clear+start, ten counting edges, stop
    wr(32'hFFFF_FFF4, 32'h3);
    rd(32'hFFFF_FFF4, rv); check("cnt_run", rv, 32'h1);
    rd(32'hFFFF_FFF0, rv); check("cnt_start0", rv, 32'h0);
    idle(9);
    wr(32'hFFFF_FFF4, 32'h0);
    rd(32'hFFFF_FFF0, rv); check("cnt_ten", rv, 32'd10);
    idle(3);
    rd(32'hFFFF_FFF0, rv); check("cnt_hold", rv, 32'd10);
    rd(32'hFFFF_FFEC, rv); check("cnt_hi32", rv, 32'h0);
    rd(32'hFFFF_FFF4, rv); check("cnt_stopped", rv, 32'h0);
    idle(1);
    wr(32'hFFFF_FFF4, 32'h2);
    rd(32'hFFFF_FFF0, rv); check("cnt_clear", rv, 32'h0);
    idle(1);

    // 40-bit counter wrap
    a40 = 32'hFFFF_FFF4; wd40 = 32'h1; wen40 = 1'b1;
    @(posedge clk); #1; wen40 = 1'b0;
    force dut40.cnt = 40'hFF_FFFF_FFFF;
    #1;
    release dut40.cnt;
    a40 = 32'hFFFF_FFEC; #1; check("w40_hi_pre", rd40, 32'h0000_00FF);
    a40 = 32'hFFFF_FFF0; #1; check("w40_lo_pre", rd40, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    a40 = 32'hFFFF_FFF0; #1; check("w40_lo_wrap", rd40, 32'h0);
    a40 = 32'hFFFF_FFEC; #1; check("w40_hi_wrap", rd40, 32'h0);
    idle(1);

    // Reset mid-drain with 3 bytes queued
    for (int i = 0; i < 3; i++) wr(32'hFFFF_FFFC, 32'(8'h71 + i));
    check("q3_data", 32'(uartData), 32'h71);
    #2; rst = 1'b1; #1;
    check("rst_mid_valid", 32'(uartValid), 32'h0);
    check("rst_mid_data", 32'(uartData), 32'h0);
    @(negedge clk); rst = 1'b0;
    idle(1);
    rd(32'hFFFF_FFF8, rv); check("rst_mid_stat", rv, 32'h0000_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
